i2c_byte_ctrl: RTL and testbench
================================

I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles per PHY bit operation (used only with the timeout feature).
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_start  input  1  issue START or repeated START first.
REQ-007 cmd_write  input  1  write cmd_data byte, then sample slave ACK.
REQ-008 cmd_read  input  1  read one byte, then drive master ACK/NACK.
REQ-009 cmd_last  input  1  on read: 1 = send NACK, 0 = send ACK.
REQ-010 cmd_stop  input  1  issue STOP last.
REQ-011 cmd_data  input  8  write byte, MSB first.
REQ-012 done  output  1  one-cycle pulse when the command completes.
REQ-013 rd_data  output  8  received byte, valid with done after a read.
REQ-014 nack  output  1  valid with done: slave NACKed the write byte.
REQ-015 timeout  output  1  valid with done: watchdog fired (0 when feature absent).
REQ-016 phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data, phy_release_bus  output  1 each  PHY bit commands.
REQ-017 phy_state  input  5  PHY state (0 = IDLE, 1 = ACTIVE, other values = bit in progress).
REQ-018 phy_rx_data  input  1  last bit sampled by the PHY.
REQ-019 bus_control  input  1  PHY owns the bus.

Function
REQ-020 Sequencer states: IDLE, START, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP, DONE.
REQ-021 cmd_ready = 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-022 Phase order per command: START (if cmd_start), then write or read (if set), then STOP (if cmd_stop).
REQ-023 cmd_read takes priority when cmd_read and cmd_write are both set; the write is ignored.
REQ-024 Accepting a command with no phase bits set goes straight to DONE.
REQ-025 Bit handshake: assert exactly one phy_*_bit as a level until phy_state leaves {0,1}, then deassert.
REQ-026 After deassertion, wait for phy_state = 1, or 0 after STOP; that cycle completes the bit.
REQ-027 A bit command is asserted only while phy_state is 0 (START) or 1 (all other phases).
REQ-028 A non-START phase with bus_control = 0 skips to DONE with nack = 1.
REQ-029 WR_BIT: 3-bit counter 7..0; phy_tx_data = cmd_data[counter], held stable for the whole bit.
REQ-030 WR_ACK: phy_read_bit; nack = phy_rx_data at completion; after a NACK, STOP still runs if requested.
REQ-031 RD_BIT: 8 phy_read_bit operations; phy_rx_data shifted into rd_data MSB first at each completion.
REQ-032 RD_ACK: phy_write_bit with phy_tx_data = cmd_last.
REQ-033 DONE: done = 1 for one cycle, then IDLE.
REQ-034 rd_data, nack and timeout hold their values until the next accept, which clears nack and timeout.
REQ-035 cmd_* inputs are latched at accept; later input changes have no effect until DONE.
REQ-036 phy_release_bus = 0 except as defined in REQ-043.

Reset
REQ-037 rst_n = 0 sampled on posedge: state IDLE, counter 0, all phy_* outputs 0.
REQ-038 Reset values of other outputs: cmd_ready 1 on the first cycle after reset, done 0, rd_data 0, nack 0, timeout 0.
REQ-039 Reset mid-operation aborts the sequencer without driving phy_release_bus; the PHY shares the reset.

Configuration
REQ-040 Macro I2C_BYTE_CTRL_TIMEOUT_EN compiles in a watchdog.
REQ-041 Watchdog counter: 16 bits (clog2 of TIMEOUT_CYCLES+1 when larger); cleared at every bit command assertion; increments while a bit is outstanding.
REQ-042 Without the macro: no counter, timeout tied 0, phy_release_bus tied 0.
REQ-043 With the macro, on count = TIMEOUT_CYCLES: phy_release_bus = 1 for one cycle, all phy_*_bit deasserted, timeout = 1, go to DONE.

Verification
REQ-044 Reset: rst_n low 2 cycles -> all outputs at reset values; cmd_ready = 1 after release.
REQ-045 Write 0xA5 with start+stop to a slave model that ACKs -> PHY sees start, bits 1,0,1,0,0,1,0,1, read, stop; done with nack = 0.
REQ-046 Read with start+stop+last, slave returns 0x3C -> rd_data = 0x3C; phy_tx_data = 1 on the ACK bit; done = 1.
REQ-047 Write 0x50 to a slave that NACKs, with stop -> nack = 1; STOP still issued; bus_control = 0 after done.
REQ-048 With I2C_BYTE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 100, SCL held low -> phy_release_bus pulse at cycle 100 of the stalled bit; done with timeout = 1.
REQ-049 Command with cmd_read = 0, cmd_write = 1, no start, while bus_control = 0 -> immediate done with nack = 1; no phy_*_bit asserted.

Source files
------------

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C command sequencer: turns START/WRITE/READ/STOP commands into PHY bit operations.
// Optional watchdog compiled in with `define I2C_BYTE_CTRL_TIMEOUT_EN.
module i2c_byte_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_last,
    input  logic       cmd_stop,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       nack,
    output logic       timeout,
    output logic       phy_start_bit,
    output logic       phy_stop_bit,
    output logic       phy_write_bit,
    output logic       phy_read_bit,
    output logic       phy_tx_data,
    output logic       phy_release_bus,
    input  logic [4:0] phy_state,
    input  logic       phy_rx_data,
    input  logic       bus_control
);
    typedef enum logic [2:0] {
        IDLE, START, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP, DONE
    } state_t;

    state_t     state_q, state_d;
    logic       c_read, c_write, c_last, c_stop;
    logic [7:0] c_data;
    logic [2:0] cnt_q;
    logic       bit_req_q, bit_wait_q;
    logic [7:0] rd_data_q;
    logic       nack_q;
    logic       accept, issue, drop, complete, skip, wd_fire, bit_on;

    // Phase that follows START (or acceptance when no START is requested).
    function automatic state_t data_phase(input logic rd, input logic wr, input logic stp);
        if (rd)
            return RD_BIT;
        else if (wr)
            return WR_BIT;
        else if (stp)
            return STOP;
        else
            return DONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        issue    = 1'b0;
        drop     = 1'b0;
        complete = 1'b0;
        skip     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_start ? START : data_phase(cmd_read, cmd_write, cmd_stop);
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (wd_fire) begin
                    state_d = DONE;
                end else if (!bit_req_q && !bit_wait_q) begin
                    if (state_q != START && !bus_control) begin
                        skip    = 1'b1;
                        state_d = DONE;
                    end else if (phy_state == ((state_q == START) ? 5'd0 : 5'd1)) begin
                        issue = 1'b1;
                    end
                end else if (bit_req_q) begin
                    drop = (phy_state > 5'd1);
                end else if (phy_state == ((state_q == STOP) ? 5'd0 : 5'd1)) begin
                    complete = 1'b1;
                    case (state_q)
                        START:   state_d = data_phase(c_read, c_write, c_stop);
                        WR_BIT:  state_d = (cnt_q == 3'd0) ? WR_ACK : WR_BIT;
                        RD_BIT:  state_d = (cnt_q == 3'd0) ? RD_ACK : RD_BIT;
                        WR_ACK,
                        RD_ACK:  state_d = c_stop ? STOP : DONE;
                        default: state_d = DONE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_read     <= 1'b0;
            c_write    <= 1'b0;
            c_last     <= 1'b0;
            c_stop     <= 1'b0;
            cnt_q      <= 3'd0;
            bit_req_q  <= 1'b0;
            bit_wait_q <= 1'b0;
            rd_data_q  <= 8'd0;
            nack_q     <= 1'b0;
        end else begin
            if (accept) begin
                c_read  <= cmd_read;
                c_write <= cmd_write & ~cmd_read;
                c_last  <= cmd_last;
                c_stop  <= cmd_stop;
            end
            if (wd_fire) begin
                bit_req_q  <= 1'b0;
                bit_wait_q <= 1'b0;
            end else if (issue) begin
                bit_req_q <= 1'b1;
            end else if (drop) begin
                bit_req_q  <= 1'b0;
                bit_wait_q <= 1'b1;
            end else if (complete) begin
                bit_wait_q <= 1'b0;
            end
            if (state_d != state_q && (state_d == WR_BIT || state_d == RD_BIT))
                cnt_q <= 3'd7;
            else if (complete && (state_q == WR_BIT || state_q == RD_BIT))
                cnt_q <= cnt_q - 3'd1;
            if (complete && state_q == RD_BIT)
                rd_data_q <= {rd_data_q[6:0], phy_rx_data};
            if (accept)
                nack_q <= 1'b0;
            else if (skip)
                nack_q <= 1'b1;
            else if (complete && state_q == WR_ACK)
                nack_q <= phy_rx_data;
        end
    end

    // The write byte is only observed during WR_BIT, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept)
            c_data <= cmd_data;
    end

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    localparam int WD_NEED = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W    = (WD_NEED > 16) ? WD_NEED : 16;

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    assign wd_fire = (bit_req_q || bit_wait_q) && (wd_q == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (issue)
                wd_q <= '0;
            else if (bit_req_q || bit_wait_q)
                wd_q <= wd_q + WD_W'(1);
            if (accept)
                timeout_q <= 1'b0;
            else if (wd_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout         = timeout_q;
    assign phy_release_bus = wd_fire;
`else
    assign wd_fire         = 1'b0;
    assign timeout         = 1'b0;
    assign phy_release_bus = 1'b0;
`endif

    assign bit_on        = bit_req_q && !wd_fire;
    assign phy_start_bit = bit_on && (state_q == START);
    assign phy_stop_bit  = bit_on && (state_q == STOP);
    assign phy_write_bit = bit_on && (state_q == WR_BIT || state_q == RD_ACK);
    assign phy_read_bit  = bit_on && (state_q == RD_BIT || state_q == WR_ACK);

    always_comb begin
        phy_tx_data = 1'b0;
        if (state_q == WR_BIT)
            phy_tx_data = c_data[cnt_q];
        else if (state_q == RD_ACK)
            phy_tx_data = c_last;
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign rd_data   = rd_data_q;
    assign nack      = nack_q;
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Self-checking bench for i2c_byte_ctrl: PHY/slave model, transaction-level expectations, per-cycle compare.
// Define I2C_BYTE_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_i2c_byte_ctrl;
    localparam logic [7:0] OP_S = 8'h53;
    localparam logic [7:0] OP_P = 8'h50;
    localparam logic [7:0] OP_R = 8'h52;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_start, cmd_write, cmd_read, cmd_last, cmd_stop;
    logic [7:0] cmd_data;
    logic       done, nack, timeout;
    logic [7:0] rd_data;
    logic       phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data, phy_release_bus;
    logic [4:0] phy_state;
    logic       phy_rx_data, bus_control;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [7:0] ops[$];
    logic [7:0] exp_ops[$];
    logic [7:0] exp_rd = 8'd0;
    logic       exp_nack = 1'b0;
    logic       exp_to = 1'b0;
    logic [7:0] slave_byte = 8'd0;
    logic       slave_nack = 1'b0;
    logic       cur_is_read = 1'b0;
    logic       cur_tx = 1'b0;
    logic       stall = 1'b0;
    logic       in_flight = 1'b0;
    logic       chk_en = 1'b0;
    int         read_idx = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    i2c_byte_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_last(cmd_last), .cmd_stop(cmd_stop), .cmd_data(cmd_data),
        .done(done), .rd_data(rd_data), .nack(nack), .timeout(timeout),
        .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
        .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
        .phy_tx_data(phy_tx_data), .phy_release_bus(phy_release_bus),
        .phy_state(phy_state), .phy_rx_data(phy_rx_data), .bus_control(bus_control)
    );

    function automatic logic [7:0] op_w(input logic b);
        return {7'h08, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] op_at(input int i);
        if (i < ops.size())
            return ops[i];
        return 8'hFF;
    endfunction

    // PHY + slave model: each bit takes a few cycles in a busy state, then settles.
    initial begin
        int busy;
        logic [4:0] end_st;
        logic stop_pend;
        busy = 0; end_st = 5'd0; stop_pend = 1'b0;
        phy_state = 5'd0; bus_control = 1'b0; phy_rx_data = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                phy_state = 5'd0; bus_control = 1'b0; busy = 0; stop_pend = 1'b0;
                continue;
            end
            if (busy > 0) begin
                if (!stall) begin
                    busy--;
                    if (busy == 0) begin
                        phy_state = end_st;
                        if (stop_pend) begin
                            bus_control = 1'b0;
                            stop_pend = 1'b0;
                        end
                    end
                end
            end else if (phy_start_bit || phy_stop_bit || phy_write_bit || phy_read_bit) begin
                check("bit_gate", {27'd0, phy_state}, phy_start_bit ? 32'd0 : 32'd1);
                busy = 3; phy_state = 5'd2; end_st = 5'd1;
                if (phy_start_bit) begin
                    ops.push_back(OP_S);
                    bus_control = 1'b1;
                end else if (phy_stop_bit) begin
                    ops.push_back(OP_P);
                    end_st = 5'd0;
                    stop_pend = 1'b1;
                end else if (phy_write_bit) begin
                    ops.push_back(op_w(phy_tx_data));
                    cur_tx = phy_tx_data;
                end else begin
                    ops.push_back(OP_R);
                    if (cur_is_read && read_idx < 8) begin
                        phy_rx_data = slave_byte[7 - read_idx];
                        read_idx++;
                    end else begin
                        phy_rx_data = slave_nack;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the transaction-level expectations.
    initial begin
        int nbits;
        forever begin
            @(negedge clk);
            if (!rst_n || !chk_en) begin
                in_flight = 1'b0;
                continue;
            end
            nbits = int'(phy_start_bit) + int'(phy_stop_bit) + int'(phy_write_bit) + int'(phy_read_bit);
            check("one_bit_cmd", nbits <= 1, 1);
            check("cmd_ready", cmd_ready, !in_flight);
            if (phy_write_bit)
                check("tx_stable", phy_tx_data, cur_tx);
`ifndef I2C_BYTE_CTRL_TIMEOUT_EN
            check("release_low", phy_release_bus, 0);
`endif
            if (done) begin
                check("done_nack", nack, exp_nack);
                check("done_rd_data", rd_data, exp_rd);
                check("done_timeout", timeout, exp_to);
                if (!exp_to) begin
                    check("ops_len", ops.size(), exp_ops.size());
                    for (int i = 0; i < exp_ops.size(); i++)
                        check("ops_item", op_at(i), exp_ops[i]);
                end
                in_flight = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic wait_done(input int start_cnt);
        int waited;
        waited = 0;
        while (done_cnt == start_cnt && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", done_cnt != start_cnt, 1);
    endtask

    task automatic run_cmd(input logic s, input logic w, input logic r, input logic l, input logic p,
                           input logic [7:0] d, input logic [7:0] sb, input logic sn);
        int start_cnt;
        exp_ops.delete();
        exp_to = 1'b0;
        if (!(s || bus_control) && (r || w || p)) begin
            exp_nack = 1'b1;
        end else begin
            if (s) exp_ops.push_back(OP_S);
            if (r) begin
                for (int i = 0; i < 8; i++) exp_ops.push_back(OP_R);
                exp_ops.push_back(op_w(l));
                exp_rd = sb;
            end else if (w) begin
                for (int i = 7; i >= 0; i--) exp_ops.push_back(op_w(d[i]));
                exp_ops.push_back(OP_R);
            end
            if (p) exp_ops.push_back(OP_P);
            exp_nack = (!r && w) ? sn : 1'b0;
        end
        ops.delete();
        read_idx = 0; cur_is_read = r; slave_byte = sb; slave_nack = sn;
        start_cnt = done_cnt;
        @(negedge clk);
        cmd_start = s; cmd_write = w; cmd_read = r; cmd_last = l; cmd_stop = p; cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        in_flight = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = ~s; cmd_write = ~w; cmd_read = ~r; cmd_last = ~l; cmd_stop = ~p; cmd_data = ~d;
        wait_done(start_cnt);
    endtask

    initial begin
        logic [7:0] wbyte;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
        cmd_read = 1'b0; cmd_last = 1'b0; cmd_stop = 1'b0; cmd_data = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_phy_bits", {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data}, 0);
        check("rst_release", phy_release_bus, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_nack", nack, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        chk_en = 1'b1;

        // Write 0xA5 with start+stop, slave ACKs
        run_cmd(1, 1, 0, 0, 1, 8'hA5, 8'h00, 0);
        wbyte = 8'd0;
        for (int i = 1; i <= 8; i++) wbyte = {wbyte[6:0], op_at(i)[0]};
        check("a5_bits", wbyte, 8'hA5);
        check("a5_start_first", op_at(0), OP_S);
        check("a5_stop_last", op_at(10), OP_P);
        check("a5_nack", nack, 0);

        // Read with start+stop+last, slave returns 0x3C
        run_cmd(1, 0, 1, 1, 1, 8'h00, 8'h3C, 0);
        check("rd_3c", rd_data, 8'h3C);
        check("rd_ack_tx1", op_at(9), 8'h11);

        // Write 0x50 to a NACKing slave, STOP still issued
        run_cmd(1, 1, 0, 0, 1, 8'h50, 8'h00, 1);
        check("nack_set", nack, 1);
        check("nack_stop_issued", op_at(10), OP_P);
        check("nack_bus_released", bus_control, 0);

        // Write without start while the bus is not owned
        run_cmd(0, 1, 0, 0, 0, 8'h77, 8'h00, 0);
        check("nobus_nack", nack, 1);
        check("nobus_no_ops", ops.size(), 0);

        // Start+write without stop, then read+write (read wins), stop-only, empty
        run_cmd(1, 1, 0, 0, 0, 8'h81, 8'h00, 0);
        run_cmd(0, 1, 1, 0, 0, 8'hFF, 8'h96, 0);
        check("prio_rd", rd_data, 8'h96);
        run_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        run_cmd(0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        check("empty_nack", nack, 0);
        check("empty_rd_hold", rd_data, 8'h96);

        // Reset in the middle of a write
        ops.delete(); cur_is_read = 1'b0; slave_nack = 1'b0;
        @(negedge clk);
        cmd_start = 1; cmd_write = 1; cmd_read = 0; cmd_last = 0; cmd_stop = 1; cmd_data = 8'hFF;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        in_flight = 1'b1;
        cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_bits", {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit}, 0);
        check("midrst_release", phy_release_bus, 0);
        rst_n = 1'b1;
        exp_rd = 8'd0;
        @(negedge clk);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_rd_data", rd_data, 0);

        run_cmd(1, 1, 0, 0, 1, 8'h3C, 8'h00, 1);
        check("post_rst_nack", nack, 1);

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
        begin
            int start_cnt, w0, cyc;
            stall = 1'b1;
            exp_ops.delete(); exp_to = 1'b1; exp_nack = 1'b0;
            ops.delete();
            start_cnt = done_cnt;
            @(negedge clk);
            cmd_start = 1; cmd_write = 1; cmd_read = 0; cmd_last = 0; cmd_stop = 1; cmd_data = 8'h12;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            in_flight = 1'b1;
            cmd_valid = 1'b0;
            w0 = 0;
            while (!phy_start_bit && w0 < 50) begin
                @(negedge clk);
                w0++;
            end
            cyc = 0;
            while (!phy_release_bus && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            check("wd_release_cycle", cyc, 100);
            wait_done(start_cnt);
            check("wd_timeout", timeout, 1);
            stall = 1'b0;
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
